// File: rtl/shift_delay_timer_pkg.sv
// shift_delay_timer_pkg: state encoding and defaults shared by the delay timer.
package shift_delay_timer_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, COUNT, DONE} state_t;
    localparam int UNIT_CYCLES_DEFAULT = 1000;
    localparam int PRE_W = 10;
endpackage

// File: rtl/shift_delay_timer_unit_tick.sv
// unit_tick: loadable down-counting prescaler with a zero flag.
module unit_tick
    import shift_delay_timer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [PRE_W-1:0] load_val,
    output logic             zero
);
    logic [PRE_W-1:0] pre;
    always_ff @(posedge clk) begin
        if (reset) pre <= '0;
        else if (load) pre <= load_val;
        else if (dec && pre != '0) pre <= pre - 1'b1;
    end
    assign zero = pre == '0;
endmodule

// File: rtl/shift_delay_timer.sv
// shift_delay_timer: serially loaded 4-bit delay, counted down in units of UNIT_CYCLES clocks.
module shift_delay_timer
    import shift_delay_timer_pkg::*;
#(
    parameter int UNIT_CYCLES = UNIT_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       shift_ena,
    input  logic       data,
    input  logic       ack,
    output logic [3:0] count,
    output logic       counting,
    output logic       done
);
    localparam logic [PRE_W-1:0] RELOAD = PRE_W'(UNIT_CYCLES - 1);
    state_t     state, state_nx;
    logic [3:0] count_nx;
    logic       tick_load, tick_zero;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            state <= state_nx;
            count <= count_nx;
        end
    end
    always_comb begin
        state_nx  = state;
        count_nx  = count;
        tick_load = 1'b0;
        case (state)
            IDLE, SHIFT: begin
                if (shift_ena) begin
                    state_nx = SHIFT;
                    count_nx = {count[2:0], data};
                end else if (state == SHIFT) begin
                    state_nx  = COUNT;
                    tick_load = 1'b1;
                end
            end
            // The last unit expires with count already 0, so delay D spans D+1 units.
            COUNT: begin
                if (tick_zero) begin
                    if (count == 4'd0) state_nx = DONE;
                    else begin
                        count_nx  = count - 4'd1;
                        tick_load = 1'b1;
                    end
                end
            end
            DONE: state_nx = ack ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    assign counting = state == COUNT;
    assign done     = state == DONE;
    unit_tick u_tick (
        .clk      (clk),
        .reset    (reset),
        .load     (tick_load),
        .dec      (state == COUNT),
        .load_val (RELOAD),
        .zero     (tick_zero)
    );
endmodule
